// File: rtl/synch_ram_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// synch_ram_loader
// Writer side of a banked synchronous pattern memory. Each start pulse runs one
// load burst: bytes arriving on a valid/ready stream are turned into registered
// RAM write strobes inside a single bank, and a done pulse ends the burst.
//
// Handshake: a byte transfers on any rising edge where s_valid & s_ready are
// both 1. s_ready is decoded purely from the state register, so it never
// depends on s_valid. The source may hold s_valid with stable s_data until the
// transfer happens.
//
// Ports
//   clk, reset_n      clock (rising edge), asynchronous active-low reset
//   start, bank, len  burst request; bank and len are sampled with start in
//                     IDLE only (len = 0 means a full bank)
//   abort             end a LOAD burst early, without a done pulse
//   s_data/s_valid/s_ready  byte stream input
//   we, waddr, wdata  registered RAM write port, waddr = {bank, idx}
//   busy              burst in progress (state != IDLE)
//   done              one-cycle pulse in FINISH, together with the last write
//   count             bytes accepted in the current or last burst
//   csum              (only with CHECKSUM_EN defined) modular sum of the bytes
//                     accepted in the current burst
//
// Build option: define CHECKSUM_EN to add the csum output and its adder.
// -----------------------------------------------------------------------------
module synch_ram_loader #(
  parameter int DATA_W      = 8,
  parameter int BANK_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   bank,
  input  logic [BANK_ADDR_W-1:0] len,
  input  logic                   abort,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   we,
  output logic [BANK_ADDR_W:0]   waddr,
  output logic [DATA_W-1:0]      wdata,
  output logic                   busy,
  output logic                   done,
`ifdef CHECKSUM_EN
  output logic [DATA_W-1:0]      csum,
`endif
  output logic [BANK_ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [BANK_ADDR_W-1:0] IDX_ONE = {{(BANK_ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [BANK_ADDR_W:0]   CNT_ONE = {{BANK_ADDR_W{1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   bank_q;
  logic [BANK_ADDR_W-1:0] len_q;
  logic [BANK_ADDR_W-1:0] idx_q;
  logic [BANK_ADDR_W-1:0] last_idx;
  logic                   handshake;
  logic                   start_ok;

  // len_q - 1 wraps to all ones for len_q == 0, which is exactly the last
  // index of a full-bank burst, so no special case is needed.
  assign last_idx  = len_q - IDX_ONE;
  assign handshake = s_valid & s_ready;
  assign start_ok  = (state_q == IDLE) & start;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort: abort only acts in LOAD
        if (start) state_d = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (handshake && (idx_q == last_idx)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst parameters, write strobes and counters. A byte accepted in an abort
  // cycle still takes this path, so it is written and counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= 1'b0;
      len_q  <= '0;
      idx_q  <= '0;
      count  <= '0;
      we     <= 1'b0;
      waddr  <= '0;
      wdata  <= '0;
`ifdef CHECKSUM_EN
      csum   <= '0;
`endif
    end else begin
      we <= 1'b0;
      if (start_ok) begin
        bank_q <= bank;
        len_q  <= len;
        idx_q  <= '0;
        count  <= '0;
`ifdef CHECKSUM_EN
        csum   <= '0;
`endif
      end else if (handshake) begin
        we    <= 1'b1;
        waddr <= {bank_q, idx_q};
        wdata <= s_data;
        idx_q <= idx_q + IDX_ONE;
        count <= count + CNT_ONE;
`ifdef CHECKSUM_EN
        csum  <= csum + s_data;
`endif
      end
    end
  end

endmodule
